// File: rtl/cnt_job_sched.sv
// ----------------------------------------------------------------------------
// cnt_job_sched
//   Round-robin scheduler that shares one CW-bit up-counter between NREQ
//   requesters. A requester raises req_valid with a target count on its
//   req_len slice. The block accepts one job at a time. For that job it
//   clears the shared counter, enables it until cnt_q reaches the target,
//   and then pulses done to the owner together with a completion status.
//   A watchdog ends the job with TIMEOUT if the counter never reaches the
//   target.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rstn       in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester job request
//   req_len    in   [NREQ*CW]  per-requester target, slice i = [i*CW +: CW]
//   abort      in   cancels the job in flight (CLEAR or RUN)
//   cnt_q      in   [CW]       current value of the shared counter
//   req_ready  out  [NREQ]     one-hot accept pulse
//   cnt_clr    out  synchronous clear to the shared counter
//   cnt_en     out  count enable to the shared counter
//   busy       out  high whenever a job is in flight
//   owner      out  index of the current/last granted requester
//   done       out  [NREQ]     one-hot completion pulse
//   status     out  [2]        00 OK, 01 ABORTED, 10 TIMEOUT (valid with done)
// ----------------------------------------------------------------------------
module cnt_job_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*CW-1:0]      req_len,
    input  logic                    abort,
    input  logic [CW-1:0]           cnt_q,
    output logic [NREQ-1:0]         req_ready,
    output logic                    cnt_clr,
    output logic                    cnt_en,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [NREQ-1:0]         done,
    output logic [1:0]              status
);

    localparam int          OW       = $clog2(NREQ);
    localparam logic [CW:0] WD_LIMIT = {1'b1, {CW{1'b0}}};
    localparam logic [OW:0] NREQ_W   = (OW+1)'(NREQ);
    localparam logic [1:0]  ST_OK    = 2'b00;
    localparam logic [1:0]  ST_ABORT = 2'b01;
    localparam logic [1:0]  ST_TOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW:0]     wd_q, wd_d;
    logic [1:0]      status_q, status_d;

    logic            grant_vld_s;
    logic [OW-1:0]   grant_idx_s;
    logic [OW:0]     cand_sum_s;
    logic [CW-1:0]   len_arr_s [NREQ];
    logic            match_s;
    logic            timeout_s;
    logic [NREQ-1:0] req_ready_s;
    logic [NREQ-1:0] done_s;
    logic            cnt_clr_s;
    logic            cnt_en_s;

    // Split the packed length bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            len_arr_s[i] = req_len[i*CW +: CW];
        end
    end

    // Round-robin search: walk offsets NREQ..1 so the smallest offset from
    // ptr+1 is the last (winning) assignment.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_sum_s  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_sum_s = {1'b0, ptr_q} + (OW+1)'(k);
            if (cand_sum_s >= NREQ_W) begin
                cand_sum_s = cand_sum_s - NREQ_W;
            end else begin
                cand_sum_s = cand_sum_s;
            end
            if (req_valid[cand_sum_s[OW-1:0]]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_sum_s[OW-1:0];
            end else begin
                grant_vld_s = grant_vld_s;
                grant_idx_s = grant_idx_s;
            end
        end
    end

    assign match_s   = (cnt_q == len_q);
    assign timeout_s = (wd_q == WD_LIMIT);

    // Next-state and output decode of the job FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        len_d       = len_q;
        wd_d        = wd_q;
        status_d    = status_q;
        req_ready_s = '0;
        done_s      = '0;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    len_d                    = len_arr_s[grant_idx_s];
                    owner_d                  = grant_idx_s;
                    state_d                  = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                cnt_clr_s = 1'b1;
                wd_d      = '0;
                if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wd_d     = wd_q + 1'b1;
                // Enable stops in the very cycle the job ends so the counter
                // holds its final value.
                cnt_en_s = ~match_s & ~abort & ~timeout_s;
                if (match_s) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else if (abort) begin
                    status_d = ST_ABORT;
                    state_d  = S_DONE;
                end else if (timeout_s) begin
                    status_d = ST_TOUT;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                done_s[owner_q] = 1'b1;
                ptr_d           = owner_q;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and job-context registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            ptr_q    <= OW'(NREQ-1);
            owner_q  <= '0;
            len_q    <= '0;
            wd_q     <= '0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            len_q    <= len_d;
            wd_q     <= wd_d;
            status_q <= status_d;
        end
    end

    // The accept pulse is combinational from req_valid while idle, so it is
    // masked by rstn to keep it low during reset with requests pending.
    assign req_ready = rstn ? req_ready_s : '0;
    assign done      = done_s;
    assign cnt_clr   = cnt_clr_s;
    assign cnt_en    = cnt_en_s;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q;
    assign status    = (state_q == S_DONE) ? status_q : 2'b00;

endmodule
